// File: rtl/vram_port_arbiter.sv
// VRAM port A arbiter: round-robin valid/ready sharing between two requesters,
// tagged read returns and a full-frame clear engine. Option: VRAM_ARB_FIXED_PRIO_EN.
module vram_port_arbiter #(
    parameter int TOTAL_BYTES = 230400,
    parameter int ADDR_W      = 18
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              R0_VALID,
    output logic              R0_READY,
    input  logic              R0_WE,
    input  logic [ADDR_W-1:0] R0_ADDR,
    input  logic [7:0]        R0_WDATA,
    output logic              R0_RVALID,
    output logic [7:0]        R0_RDATA,

    input  logic              R1_VALID,
    output logic              R1_READY,
    input  logic              R1_WE,
    input  logic [ADDR_W-1:0] R1_ADDR,
    input  logic [7:0]        R1_WDATA,
    output logic              R1_RVALID,
    output logic [7:0]        R1_RDATA,

    input  logic              CLEAR_START,
    input  logic [7:0]        CLEAR_VALUE,
    output logic              CLEAR_BUSY,
    output logic              CLEAR_DONE,

    output logic [ADDR_W-1:0] VRAM_ADDR,
    output logic [7:0]        VRAM_DATA,
    output logic              VRAM_WE,
    input  logic [7:0]        VRAM_Q
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_BYTES - 1);
    localparam logic [ADDR_W:0]   FILL_END  = (ADDR_W + 1)'(TOTAL_BYTES);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              clear_go;
    logic              fill_last;
    logic [ADDR_W:0]   fill_count;
    logic [7:0]        fill_value;

    logic              sel_owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;
    logic              sel_oor;

    logic              ret_valid1;
    logic              ret_owner1;
    logic              ret_oor1;
    logic              ret_valid2;
    logic              ret_owner2;
    logic              ret_oor2;

    assign accept = grant0 | grant1;

`ifdef VRAM_ARB_FIXED_PRIO_EN
    // Fixed priority needs no fairness history.
`else
    // last holds the most recent winner; reset to R1 so R0 takes the first tie.
    logic last;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A clear request pre-empts arbitration; requests are also held off during
    // the CLEAR_DONE cycle so a blocked requester is taken the cycle after it.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        clear_go   = 1'b0;
        fill_last  = 1'b0;
        case (state)
            IDLE: begin
                if (CLEAR_START) begin
                    clear_go   = 1'b1;
                    state_next = CLEAR;
                end else if (!CLEAR_DONE) begin
`ifdef VRAM_ARB_FIXED_PRIO_EN
                    grant0 = R0_VALID;
                    grant1 = R1_VALID && !R0_VALID;
`else
                    grant0 = R0_VALID && (!R1_VALID || last);
                    grant1 = R1_VALID && (!R0_VALID || !last);
`endif
                end
            end
            CLEAR: begin
                if (fill_count == FILL_END) begin
                    fill_last  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign R0_READY   = grant0;
    assign R1_READY   = grant1;
    assign CLEAR_BUSY = (state == CLEAR);

    always_comb begin
        sel_owner = grant1;
        sel_we    = grant1 ? R1_WE    : R0_WE;
        sel_addr  = grant1 ? R1_ADDR  : R0_ADDR;
        sel_wdata = grant1 ? R1_WDATA : R0_WDATA;
        sel_oor   = (sel_addr > LAST_ADDR);
    end

    // The counter runs one ahead of the address on the port, so reaching
    // FILL_END means the final fill write is already on VRAM_ADDR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fill_count <= '0;
            fill_value <= 8'h00;
        end else if (clear_go) begin
            fill_count <= (ADDR_W + 1)'(1);
            fill_value <= CLEAR_VALUE;
        end else if (fill_last) begin
            fill_count <= '0;
        end else if (state == CLEAR) begin
            fill_count <= fill_count + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            VRAM_ADDR  <= '0;
            VRAM_DATA  <= 8'h00;
            VRAM_WE    <= 1'b0;
            CLEAR_DONE <= 1'b0;
        end else begin
            CLEAR_DONE <= fill_last;
            if (clear_go) begin
                VRAM_ADDR <= '0;
                VRAM_DATA <= CLEAR_VALUE;
                VRAM_WE   <= 1'b1;
            end else if ((state == CLEAR) && !fill_last) begin
                VRAM_ADDR <= fill_count[ADDR_W-1:0];
                VRAM_DATA <= fill_value;
                VRAM_WE   <= 1'b1;
            end else if (accept) begin
                VRAM_ADDR <= sel_addr;
                VRAM_DATA <= sel_wdata;
                VRAM_WE   <= sel_we && !sel_oor;
            end else begin
                VRAM_WE   <= 1'b0;
            end
        end
    end

    // Two-stage owner tag lines up with the RAM's one-cycle read latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ret_valid1 <= 1'b0;
            ret_owner1 <= 1'b0;
            ret_oor1   <= 1'b0;
            ret_valid2 <= 1'b0;
            ret_owner2 <= 1'b0;
            ret_oor2   <= 1'b0;
        end else begin
            ret_valid1 <= accept && !sel_we;
            ret_owner1 <= sel_owner;
            ret_oor1   <= sel_oor;
            ret_valid2 <= ret_valid1;
            ret_owner2 <= ret_owner1;
            ret_oor2   <= ret_oor1;
        end
    end

    assign R0_RVALID = ret_valid2 && !ret_owner2;
    assign R1_RVALID = ret_valid2 && ret_owner2;
    assign R0_RDATA  = (R0_RVALID && !ret_oor2) ? VRAM_Q : 8'h00;
    assign R1_RDATA  = (R1_RVALID && !ret_oor2) ? VRAM_Q : 8'h00;

endmodule
